gen_ce_multi: RTL and testbench
===============================

GEN_CE_MULTI -- requirements
Module: gen_ce_multi

Interface
REQ-001 The block SHALL have parameter F_CLK, default 50000000, input clock frequency in Hz.
REQ-002 The block SHALL have parameter F_BASE, default 1000, base tick frequency in Hz; DIV = F_CLK/F_BASE, integer division, DIV >= 2.
REQ-003 The block SHALL have parameter NCH, default 4, number of channels, 1..16.
REQ-004 The block SHALL have parameter W, default 16, channel period width in bits.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: global enable for the prescaler.
REQ-008 The block SHALL have port ld, input, NCH bits: per-channel load strobe.
REQ-009 The block SHALL have port period, input, NCH*W bits: channel i period, in base ticks, at bits [i*W +: W].
REQ-010 The block SHALL have port oneshot, input, NCH bits: per-channel mode sampled on ld, 1 = one-shot, 0 = periodic.
REQ-011 The block SHALL have port ce_base, output, 1 bit: base tick, one clk wide.
REQ-012 The block SHALL have port ce, output, NCH bits: channel tick, one clk wide, registered.
REQ-013 The block SHALL have port busy, output, NCH bits: channel armed and counting.

Function
REQ-014 The prescaler SHALL be a 32-bit down-counter pre that holds while en=0 and, while en=1, reloads to DIV-1 at 0 and otherwise decrements.
REQ-015 ce_base SHALL be combinational (pre==0)&en: high on every DIV-th enabled cycle and low whenever en=0.
REQ-016 On ld[i]=1 with a nonzero period slice, channel i SHALL capture per[i] and mode[i], set cnt[i] = period-1 and set busy[i]=1 at that edge.
REQ-017 On ld[i]=1 with a zero period slice, channel i SHALL clear busy[i], stop, and raise no ce[i].
REQ-018 When ce_base=1, busy[i]=1, ld[i]=0 and cnt[i]!=0, cnt[i] SHALL decrement.
REQ-019 When ce_base=1, busy[i]=1, ld[i]=0 and cnt[i]==0, ce[i] SHALL be 1 in the next clk cycle only.
REQ-020 In the REQ-019 case, a periodic channel SHALL reload cnt[i]=per[i]-1; a one-shot channel SHALL clear busy[i].
REQ-021 Latency: after a load of period P, the first ce[i] SHALL follow the P-th subsequent ce_base by exactly one clk.
REQ-022 ld[i] SHALL win over a coincident ce_base: the channel reloads, that tick is not counted, and no ce[i] is produced.
REQ-023 With P=1 periodic, ce[i] SHALL pulse one clk after every ce_base.
REQ-024 With P = 2^W - 1, cnt SHALL count the full range without wrap or truncation; no arithmetic SHALL exceed W bits per channel.
REQ-025 Channels SHALL be independent; any ld combination in one cycle SHALL be legal.
REQ-026 Idle channels (busy=0) SHALL hold cnt[i] and keep ce[i]=0.
REQ-027 en=0 SHALL freeze all channel counts without clearing busy.

Reset
REQ-028 On rst=1, asynchronously: pre=DIV-1, cnt=0, per=0, mode=0, busy=0, ce=0 (and tgl=0 when configured).
REQ-029 Reset asserted mid-count SHALL discard all pending ticks; after release no ce SHALL appear until a new ld.
REQ-030 With en=1 continuously from reset release, the first ce_base SHALL occur in the DIV-th clk cycle.

Configuration
REQ-031 With macro GEN_CE_TGL_EN defined, the block SHALL add output port tgl, NCH bits, where tgl[i] inverts in the same cycle ce[i]=1 and is unaffected by ld.
REQ-032 Without GEN_CE_TGL_EN, port tgl and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification (F_CLK=10, F_BASE=1, DIV=10, NCH=2, W=4)
REQ-033 en=1 after reset -> ce_base high in cycles 10, 20, 30, never two adjacent cycles.
REQ-034 ld[0], period=3, periodic -> ce[0] one clk after the 3rd, 6th and 9th ce_base; busy[0] stays 1.
REQ-035 ld[1], period=2, one-shot -> a single ce[1] one clk after the 2nd ce_base, then busy[1]=0 with no further ce[1].
REQ-036 ld[0] coincident with ce_base while cnt[0]==0 -> no ce[0] that tick; the next ce[0] follows the P-th later ce_base.
REQ-037 en=0 for 25 cycles mid-count, then rst pulse -> counts frozen during en=0; after rst all outputs 0 and pre=9.
REQ-038 GEN_CE_TGL_EN defined, period=1 periodic -> tgl[0] toggles every 10 cycles, 50% duty.

Source files
------------

// File: rtl/gen_ce_multi.sv
// Multi-channel clock-enable generator: one shared prescaler plus NCH programmable tick channels.
// Defining GEN_CE_TGL_EN adds the per-channel toggle output tgl.
module gen_ce_multi #(
    parameter int F_CLK  = 50000000,
    parameter int F_BASE = 1000,
    parameter int NCH    = 4,
    parameter int W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NCH-1:0]    ld,
    input  logic [NCH*W-1:0]  period,
    input  logic [NCH-1:0]    oneshot,
    output logic              ce_base,
    output logic [NCH-1:0]    ce,
    output logic [NCH-1:0]    busy
`ifdef GEN_CE_TGL_EN
    ,
    output logic [NCH-1:0]    tgl
`endif
);

    localparam int DIV = F_CLK / F_BASE;
    localparam logic [31:0]  PRE_LOAD = 32'(DIV - 1);
    localparam logic [W-1:0] ONE      = W'(1);

    logic [31:0]    pre;
    logic [W-1:0]   cnt [NCH];
    logic [W-1:0]   per [NCH];
    logic [NCH-1:0] mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= PRE_LOAD;
        end else if (en) begin
            if (pre == 32'd0) begin
                pre <= PRE_LOAD;
            end else begin
                pre <= pre - 32'd1;
            end
        end
    end

    assign ce_base = (pre == 32'd0) & en;

    // A load always beats a coincident base tick; a zero period parks the channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
                per[i] <= '0;
            end
            mode <= '0;
            busy <= '0;
            ce   <= '0;
`ifdef GEN_CE_TGL_EN
            tgl  <= '0;
`endif
        end else begin
            for (int i = 0; i < NCH; i++) begin
                ce[i] <= 1'b0;
                if (ld[i]) begin
                    if (period[i*W +: W] != '0) begin
                        per[i]  <= period[i*W +: W];
                        mode[i] <= oneshot[i];
                        cnt[i]  <= period[i*W +: W] - ONE;
                        busy[i] <= 1'b1;
                    end else begin
                        busy[i] <= 1'b0;
                    end
                end else if (ce_base && busy[i]) begin
                    if (cnt[i] != '0) begin
                        cnt[i] <= cnt[i] - ONE;
                    end else begin
                        ce[i] <= 1'b1;
`ifdef GEN_CE_TGL_EN
                        tgl[i] <= ~tgl[i];
`endif
                        if (mode[i]) begin
                            busy[i] <= 1'b0;
                        end else begin
                            cnt[i] <= per[i] - ONE;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gen_ce_multi.sv
// Directed self-checking bench for gen_ce_multi (DIV=10, NCH=2, W=4).
// Toggle output is exercised when GEN_CE_TGL_EN is defined.
module tb_gen_ce_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] ld;
    logic [7:0] period;
    logic [1:0] oneshot;
    logic       ce_base;
    logic [1:0] ce;
    logic [1:0] busy;
`ifdef GEN_CE_TGL_EN
    logic [1:0] tgl;
`endif

    int checks = 0;
    int errors = 0;

    gen_ce_multi #(
        .F_CLK(10), .F_BASE(1), .NCH(2), .W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .ld(ld),
        .period(period),
        .oneshot(oneshot),
        .ce_base(ce_base),
        .ce(ce),
        .busy(busy)
`ifdef GEN_CE_TGL_EN
        ,
        .tgl(tgl)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Align to a base tick, bounded so a dead prescaler cannot hang the run.
    task automatic wait_base;
        int n = 0;
        while (ce_base !== 1'b1 && n < 25) begin
            tick();
            n++;
        end
        checks++;
        if (ce_base !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_base: ce_base=%b required 1 within 25 cycles", ce_base);
        end
    endtask

    // Leaves the bench at the cycle after the load edge, prescaler at 8.
    task automatic load(input logic [1:0] l, input logic [7:0] p, input logic [1:0] os);
        wait_base();
        tick();
        ld      = l;
        period  = p;
        oneshot = os;
        tick();
        ld = 2'b00;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; ld = 2'b00; period = 8'h00; oneshot = 2'b00;
        tick();
        tick();
        checks++;
        if (ce !== 2'b00) begin errors++; $display("[TB] FAIL reset_ce: got %b required 00", ce); end
        checks++;
        if (busy !== 2'b00) begin errors++; $display("[TB] FAIL reset_busy: got %b required 00", busy); end
        checks++;
        if (ce_base !== 1'b0) begin errors++; $display("[TB] FAIL reset_ce_base: got %b required 0", ce_base); end
        checks++;
        if (dut.pre !== 32'd9) begin errors++; $display("[TB] FAIL reset_pre: got %0d required 9", dut.pre); end
    endtask

    task automatic test_base;
        en = 1'b1;
        checks++;
        if (ce_base !== 1'b0) begin errors++; $display("[TB] FAIL base_in_reset: got %b required 0", ce_base); end
        rst = 1'b0;
        for (int k = 0; k < 35; k++) begin
            checks++;
            if (ce_base !== (k % 10 == 9)) begin
                errors++;
                $display("[TB] FAIL base_k%0d: ce_base=%b required %b", k, ce_base, (k % 10 == 9));
            end
            tick();
        end
    endtask

    task automatic test_periodic;
        load(2'b01, 8'h03, 2'b00);
        for (int j = 0; j < 96; j++) begin
            checks++;
            if (ce[0] !== (j == 29 || j == 59 || j == 89)) begin
                errors++;
                $display("[TB] FAIL periodic_ce0_j%0d: got %b required %b", j, ce[0], (j == 29 || j == 59 || j == 89));
            end
            checks++;
            if (busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL periodic_busy0_j%0d: got %b required 1", j, busy[0]); end
            checks++;
            if (ce[1] !== 1'b0) begin errors++; $display("[TB] FAIL periodic_ce1_j%0d: got %b required 0", j, ce[1]); end
            tick();
        end
    endtask

    task automatic test_oneshot;
        load(2'b11, 8'h20, 2'b10);
        for (int j = 0; j < 61; j++) begin
            checks++;
            if (ce[1] !== (j == 19)) begin
                errors++;
                $display("[TB] FAIL oneshot_ce1_j%0d: got %b required %b", j, ce[1], (j == 19));
            end
            checks++;
            if (busy[1] !== (j < 19)) begin
                errors++;
                $display("[TB] FAIL oneshot_busy1_j%0d: got %b required %b", j, busy[1], (j < 19));
            end
            checks++;
            if ({busy[0], ce[0]} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL stop_ch0_j%0d: busy/ce=%b required 00", j, {busy[0], ce[0]});
            end
            tick();
        end
    endtask

    task automatic test_coincident;
        load(2'b01, 8'h03, 2'b00);
        for (int j = 0; j < 71; j++) begin
            checks++;
            if (ce[0] !== (j == 49 || j == 69)) begin
                errors++;
                $display("[TB] FAIL coincident_ce0_j%0d: got %b required %b", j, ce[0], (j == 49 || j == 69));
            end
            if (j == 28) begin
                checks++;
                if (ce_base !== 1'b1) begin errors++; $display("[TB] FAIL coincident_sync: ce_base=%b required 1", ce_base); end
                ld     = 2'b01;
                period = 8'h02;
            end
            tick();
            ld = 2'b00;
        end
    endtask

    task automatic test_freeze_reset;
        load(2'b01, 8'h03, 2'b00);
        repeat (10) tick();
        en = 1'b0;
        for (int j = 0; j < 25; j++) begin
            tick();
            checks++;
            if (ce_base !== 1'b0) begin errors++; $display("[TB] FAIL freeze_ce_base_j%0d: got %b required 0", j, ce_base); end
            checks++;
            if (dut.pre !== 32'd8) begin errors++; $display("[TB] FAIL freeze_pre_j%0d: got %0d required 8", j, dut.pre); end
            checks++;
            if (dut.cnt[0] !== 4'd1) begin errors++; $display("[TB] FAIL freeze_cnt0_j%0d: got %0d required 1", j, dut.cnt[0]); end
            checks++;
            if (busy !== 2'b01 || ce !== 2'b00) begin
                errors++;
                $display("[TB] FAIL freeze_busy_ce_j%0d: busy=%b ce=%b required 01/00", j, busy, ce);
            end
        end
        rst = 1'b1;
        #2;
        checks++;
        if (busy !== 2'b00 || ce !== 2'b00 || ce_base !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: busy=%b ce=%b ce_base=%b required 00/00/0", busy, ce, ce_base);
        end
        checks++;
        if (dut.pre !== 32'd9) begin errors++; $display("[TB] FAIL async_reset_pre: got %0d required 9", dut.pre); end
        tick();
        rst = 1'b0;
        en  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (ce_base !== (k % 10 == 9)) begin
                errors++;
                $display("[TB] FAIL post_reset_base_k%0d: got %b required %b", k, ce_base, (k % 10 == 9));
            end
            checks++;
            if (ce !== 2'b00 || busy !== 2'b00) begin
                errors++;
                $display("[TB] FAIL post_reset_idle_k%0d: ce=%b busy=%b required 00/00", k, ce, busy);
            end
            tick();
        end
    endtask

    task automatic test_full_range;
        load(2'b11, 8'h1F, 2'b00);
        for (int j = 0; j < 156; j++) begin
            checks++;
            if (ce[0] !== (j == 149)) begin
                errors++;
                $display("[TB] FAIL full_range_ce0_j%0d: got %b required %b", j, ce[0], (j == 149));
            end
            checks++;
            if (ce[1] !== (j % 10 == 9)) begin
                errors++;
                $display("[TB] FAIL p1_ce1_j%0d: got %b required %b", j, ce[1], (j % 10 == 9));
            end
            checks++;
            if (busy !== 2'b11) begin errors++; $display("[TB] FAIL full_range_busy_j%0d: got %b required 11", j, busy); end
`ifdef GEN_CE_TGL_EN
            checks++;
            if (tgl[1] !== (((j + 1) / 10) % 2 == 1)) begin
                errors++;
                $display("[TB] FAIL tgl1_j%0d: got %b required %b", j, tgl[1], (((j + 1) / 10) % 2 == 1));
            end
            checks++;
            if (tgl[0] !== (j >= 149)) begin
                errors++;
                $display("[TB] FAIL tgl0_j%0d: got %b required %b", j, tgl[0], (j >= 149));
            end
`endif
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_base();
        test_periodic();
        test_oneshot();
        test_coincident();
        test_freeze_reset();
        test_full_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
